// File: rtl/instruction_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue.
//   WORD_W / ADDR_W : instruction word and word-address widths
//   fetch_state_t   : fetch controller states (BOOT, FETCH, FLUSH)
package instruction_fetch_queue_pkg;

    localparam int WORD_W = 32;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instruction_fetch_queue_fetch_fifo.sv
// fetch_fifo: circular buffer of (instruction, word address) pairs.
// Ports:
//   clock, reset_n          : clock, asynchronous active-low reset
//   push, push_instr/pc     : write an entry at the tail
//   pop                     : drop the head entry
//   flush                   : empty the buffer (wins over push/pop)
//   head_instr, head_pc     : head entry, forced to 0 while empty
//   full, empty, count      : occupancy status
import instruction_fetch_queue_pkg::*;

module fetch_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = PW + 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [WORD_W-1:0] push_instr,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [WORD_W-1:0] head_instr,
    output logic [ADDR_W-1:0] head_pc,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count
);

    logic [WORD_W-1:0] instr_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // Gating the head with empty keeps the outputs at zero during and after reset.
    assign head_instr = empty ? '0 : instr_mem[rd_ptr];
    assign head_pc    = empty ? '0 : pc_mem[rd_ptr];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage carries no reset; entries are only visible once written.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: sequential instruction prefetcher with redirect.
// Issues word-address fetch requests, tags in-order responses with their pc,
// buffers them in fetch_fifo and discards responses that belong to a fetch
// stream abandoned by a redirect.
// Ports:
//   clock, reset_n                  : clock, asynchronous active-low reset
//   mem_req_valid/addr/ready        : fetch request channel
//   mem_rsp_valid/data              : in-order response channel (no backpressure)
//   redirect, redirect_addr         : flush and restart fetch at a new address
//   out_valid/instr/pc, out_ready   : instruction output channel
//   fsm_state                       : current controller state (debug)
//   flush_count                     : discarded-instruction counter, present only
//                                     when INSTRUCTION_FETCH_QUEUE_STATS_EN is defined
// Handshake: a transfer on a valid/ready pair happens in a cycle where both
// are 1; valid never waits for ready, and the payload is held while valid=1
// and ready=0.
import instruction_fetch_queue_pkg::*;

module instruction_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_rsp_valid,
    input  logic [WORD_W-1:0] mem_rsp_data,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              out_ready,
    output logic [1:0]        fsm_state
`ifdef INSTRUCTION_FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]       flush_count
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t      state;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] tail_pc;   // pc of the oldest outstanding request that will be kept
    logic [CW-1:0]     in_flight;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     count;
    logic [CW:0]       budget;
    logic [CW-1:0]     redirect_drops;
    logic              full;
    logic              empty;
    logic              req_fire;
    logic              pop;
    logic              push;
    logic              drop_rsp;

    // Requests are limited so every outstanding response has a guaranteed slot.
    assign budget        = {1'b0, count} + {1'b0, in_flight};
    assign mem_req_valid = (state != BOOT) && !redirect && !full &&
                           (budget < (CW+1)'(DEPTH));
    assign mem_req_addr  = fetch_pc;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    // A response arriving in the redirect cycle is already stale.
    assign drop_rsp       = mem_rsp_valid && (redirect || (drop_cnt != '0));
    assign push           = mem_rsp_valid && !drop_rsp;
    assign redirect_drops = in_flight - CW'(mem_rsp_valid);

    assign fsm_state = state;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_instr (mem_rsp_data),
        .push_pc    (tail_pc),
        .pop        (pop),
        .flush      (redirect),
        .head_instr (out_instr),
        .head_pc    (out_pc),
        .full       (full),
        .empty      (empty),
        .count      (count)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= BOOT;
            fetch_pc  <= RESET_PC;
            tail_pc   <= RESET_PC;
            in_flight <= '0;
            drop_cnt  <= '0;
        end else begin
            // No request fires in a redirect cycle, so this covers both paths.
            in_flight <= in_flight + CW'(req_fire) - CW'(mem_rsp_valid);
            if (redirect) begin
                fetch_pc <= redirect_addr;
                tail_pc  <= redirect_addr;
                drop_cnt <= redirect_drops;
                state    <= (redirect_drops != '0) ? FLUSH : FETCH;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + 1'b1;
                if (push)     tail_pc  <= tail_pc + 1'b1;
                if (drop_rsp) drop_cnt <= drop_cnt - 1'b1;
                case (state)
                    BOOT:    state <= FETCH;
                    FLUSH:   if (drop_cnt == '0) state <= FETCH;
                    default: state <= state;
                endcase
            end
        end
    end

`ifdef INSTRUCTION_FETCH_QUEUE_STATS_EN
    logic [CW:0] flushed_now;
    logic [32:0] stats_sum;

    // Entries popped in the redirect cycle were consumed, not flushed.
    assign flushed_now = redirect ? ({1'b0, count} - (CW+1)'(pop)) : '0;
    assign stats_sum   = {1'b0, flush_count} + 33'(flushed_now) + 33'(drop_rsp);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) flush_count <= '0;
        else          flush_count <= stats_sum[32] ? 32'hFFFF_FFFF : stats_sum[31:0];
    end
`endif

endmodule
